// File: rtl/uart_tx_ctrl_pkg.sv
// uart_tx_ctrl_pkg: shared frame constants, state encodings and types for the UART transmitter
package uart_tx_ctrl_pkg;
  localparam int WIDTH = 8;
  localparam int BIT_COUNTER_WIDTH = $clog2(WIDTH);
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD = 1'b1;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    START = 3'd1,
    DATA = 3'd2,
    PARITY = 3'd3,
    STOP = 3'd4
  } state_t;
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic par_en;
    logic par_typ;
    logic [4:0] prescale;
  } word_t;
  function automatic logic parity_bit(input logic [WIDTH-1:0] d, input logic typ);
    return typ == PAR_ODD ? ~^d : ^d;
  endfunction
endpackage

// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if: word-in handshake and per-frame settings for the UART transmitter
interface uart_tx_ctrl_if import uart_tx_ctrl_pkg::*; ();
  logic [WIDTH-1:0] P_DATA;
  logic Data_Valid;
  logic Data_Ready;
  logic PAR_EN;
  logic PAR_TYP;
  logic [4:0] Prescale;
  modport master (output P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale, input Data_Ready);
  modport slave (input P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale, output Data_Ready);
endinterface

// File: rtl/uart_tx_bit_timer.sv
// uart_tx_bit_timer: per-bit edge counter (wraps at prescale-1, 0 means 32) and data bit counter
module uart_tx_bit_timer import uart_tx_ctrl_pkg::*; (
  input logic clk,
  input logic rst,
  input logic run,
  input logic in_data,
  input logic [4:0] prescale,
  output logic bit_done,
  output logic last_bit
);
  logic [4:0] edge_cnt;
  logic [BIT_COUNTER_WIDTH-1:0] bit_cnt;
  // prescale 0 makes prescale-1 wrap to 31, giving 32-cycle bits
  assign bit_done = edge_cnt == prescale - 5'd1;
  assign last_bit = bit_cnt == BIT_COUNTER_WIDTH'(WIDTH - 1);
  always_ff @(posedge clk)
    if (rst || !run) edge_cnt <= '0;
    else edge_cnt <= bit_done ? '0 : edge_cnt + 5'd1;
  always_ff @(posedge clk)
    if (rst) bit_cnt <= '0;
    else if (in_data && bit_done) bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmitter (start, LSB-first data, optional parity, stop)
// define UART_TX_HOLD_BUF_EN to add a one-entry holding buffer for gapless frames
module uart_tx_ctrl import uart_tx_ctrl_pkg::*; (
  input logic CLK,
  input logic RST,
  uart_tx_ctrl_if.slave bus,
  output logic TX_OUT,
  output logic busy
);
  state_t state, state_n;
  word_t in_word, load_word;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [4:0] prescale_r;
  logic par_en_r, par_r, load, accept, stop_end, bit_done, last_bit, tx_n;
  assign in_word = '{data: bus.P_DATA, par_en: bus.PAR_EN, par_typ: bus.PAR_TYP, prescale: bus.Prescale};
  assign accept = bus.Data_Valid && bus.Data_Ready;
  assign stop_end = state == STOP && bit_done;
`ifdef UART_TX_HOLD_BUF_EN
  word_t hold;
  logic hold_full, take_in;
  assign bus.Data_Ready = !hold_full;
  // a word arriving while idle or exactly at stop end skips the hold register
  assign take_in = accept && (state == IDLE || stop_end);
  assign load = take_in || (stop_end && hold_full);
  assign load_word = hold_full ? hold : in_word;
  always_ff @(posedge CLK)
    if (RST) hold_full <= 1'b0;
    else if (accept && !take_in) begin
      hold <= in_word;
      hold_full <= 1'b1;
    end else if (stop_end) hold_full <= 1'b0;
`else
  assign bus.Data_Ready = state == IDLE;
  assign load = accept;
  assign load_word = in_word;
`endif
  uart_tx_bit_timer u_timer (
    .clk(CLK),
    .rst(RST),
    .run(state != IDLE),
    .in_data(state == DATA),
    .prescale(prescale_r),
    .bit_done(bit_done),
    .last_bit(last_bit)
  );
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE: state_n = load ? START : IDLE;
      START: state_n = bit_done ? DATA : START;
      DATA: state_n = !(bit_done && last_bit) ? DATA : par_en_r ? PARITY : STOP;
      PARITY: state_n = bit_done ? STOP : PARITY;
      STOP: state_n = !bit_done ? STOP : load ? START : IDLE;
      default: state_n = IDLE;
    endcase
    shreg_n = load ? load_word.data : (state == DATA && bit_done) ? shreg >> 1 : shreg;
    // line level is computed from the next state so TX_OUT leaves a flop
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? shreg_n[0] : state_n == PARITY ? par_r : 1'b1;
  end
  always_ff @(posedge CLK)
    if (RST) begin
      state <= IDLE;
      TX_OUT <= 1'b1;
      busy <= 1'b0;
      shreg <= '0;
      par_en_r <= 1'b0;
      par_r <= 1'b0;
      prescale_r <= '0;
    end else begin
      state <= state_n;
      TX_OUT <= tx_n;
      busy <= state_n != IDLE;
      shreg <= shreg_n;
      if (load) begin
        par_en_r <= load_word.par_en;
        par_r <= parity_bit(load_word.data, load_word.par_typ);
        prescale_r <= load_word.prescale;
      end
    end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: per-cycle scoreboard of TX_OUT/busy/Data_Ready for uart_tx_ctrl
module tb_uart_tx_ctrl;
  import uart_tx_ctrl_pkg::*;
`ifdef UART_TX_HOLD_BUF_EN
  localparam logic HOLD = 1'b1;
`else
  localparam logic HOLD = 1'b0;
`endif
  typedef struct {
    logic tx;
    logic busy;
    logic ready;
  } exp_t;
  logic CLK = 1'b0, RST = 1'b1, TX_OUT, busy;
  int checks = 0, errors = 0, cyc = 0, acc_cyc = 0;
  bit mon_en = 1'b0;
  exp_t q[$];
  uart_tx_ctrl_if bus();
  uart_tx_ctrl dut (.CLK(CLK), .RST(RST), .bus(bus), .TX_OUT(TX_OUT), .busy(busy));
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK)
    if (mon_en) begin
      exp_t e;
      e = q.size() != 0 ? q.pop_front() : '{1'b1, 1'b0, 1'b1};
      checks++;
      if ({TX_OUT, busy, bus.Data_Ready} !== {e.tx, e.busy, e.ready}) begin
        errors++;
        $display("FAIL line cyc=%0d tx/busy/ready got %b%b%b exp %b%b%b", cyc, TX_OUT, busy, bus.Data_Ready, e.tx, e.busy, e.ready);
      end
    end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic push_frame(input logic [WIDTH-1:0] d, input logic pe, input logic pt, input int p);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < WIDTH; i++) bits.push_back(d[i]);
    if (pe) bits.push_back(^d ^ pt);
    bits.push_back(1'b1);
    foreach (q[i]) q[i].ready = 1'b0;
    foreach (bits[b]) repeat (p) q.push_back('{bits[b], 1'b1, HOLD});
  endtask
  task automatic send(input logic [WIDTH-1:0] d, input logic pe, input logic pt, input logic [4:0] ps);
    int p = ps == 5'd0 ? 32 : int'(ps);
    bit ok = 1'b0;
    @(negedge CLK);
    #1;
    bus.P_DATA = d;
    bus.PAR_EN = pe;
    bus.PAR_TYP = pt;
    bus.Prescale = ps;
    bus.Data_Valid = 1'b1;
    for (int i = 0; i < 3000 && !ok; i++)
      if (bus.Data_Ready === 1'b1) begin
        @(posedge CLK);
        #1;
        ok = 1'b1;
        acc_cyc = cyc;
        push_frame(d, pe, pt, p);
      end else begin
        @(negedge CLK);
        #1;
      end
    bus.Data_Valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept data=%h got no accept exp accept within 3000 cycles", d);
    end
  endtask
  task automatic wait_idle(input bit scramble);
    int n = 0;
    while (q.size() != 0 && n < 5000) begin
      @(negedge CLK);
      #1;
      if (scramble) begin
        bus.P_DATA = WIDTH'($urandom);
        bus.PAR_EN = 1'($urandom);
        bus.PAR_TYP = 1'($urandom);
        bus.Prescale = 5'($urandom);
      end
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", q.size());
    end
    @(negedge CLK);
    #1;
  endtask
  task automatic test_reset();
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    checks += 3;
    if (TX_OUT !== 1'b1) begin errors++; $display("FAIL reset_tx got %b exp 1", TX_OUT); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    if (bus.Data_Ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus.Data_Ready); end
    mon_en = 1'b1;
  endtask
  task automatic test_frame(input logic [WIDTH-1:0] d, input logic pe, input logic pt, input logic [4:0] ps);
    send(d, pe, pt, ps);
    wait_idle(1'b0);
  endtask
  task automatic test_latch();
    send(8'h96, 1'b1, PAR_ODD, 5'd5);
    wait_idle(1'b1);
    bus.Prescale = 5'd3;
  endtask
  task automatic test_mid_reset();
    send(8'hA5, 1'b1, PAR_EVEN, 5'd8);
    repeat (35) @(negedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK);
    #1;
    q.delete();
    RST = 1'b0;
    checks += 2;
    if (TX_OUT !== 1'b1) begin errors++; $display("FAIL midrst_tx got %b exp 1", TX_OUT); end
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
    send(8'h3C, 1'b1, PAR_ODD, 5'd3);
    wait_idle(1'b0);
  endtask
  task automatic test_back_to_back();
    int t1;
    send(8'h55, 1'b0, PAR_EVEN, 5'd4);
    t1 = acc_cyc;
    send(8'h0F, 1'b1, PAR_ODD, 5'd6);
    checks += 2;
    if (acc_cyc - t1 !== (HOLD ? 1 : 41)) begin
      errors++;
      $display("FAIL b2b_gap got %0d exp %0d", acc_cyc - t1, HOLD ? 1 : 41);
    end
    if (bus.Data_Ready !== 1'b0) begin errors++; $display("FAIL b2b_ready got %b exp 0", bus.Data_Ready); end
    wait_idle(1'b0);
  endtask
  initial begin
    bus.P_DATA = '0;
    bus.Data_Valid = 1'b0;
    bus.PAR_EN = 1'b0;
    bus.PAR_TYP = 1'b0;
    bus.Prescale = 5'd8;
    test_reset();
    test_frame(8'hA5, 1'b1, PAR_EVEN, 5'd8);
    test_frame(8'hA5, 1'b1, PAR_ODD, 5'd8);
    test_frame(8'hA5, 1'b0, PAR_EVEN, 5'd8);
    test_frame(8'hA5, 1'b1, PAR_EVEN, 5'd0);
    test_frame(8'h3C, 1'b0, PAR_EVEN, 5'd4);
    test_frame(8'h01, 1'b1, PAR_EVEN, 5'd1);
    test_latch();
    test_mid_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
